// File: rtl/systolic_seq_ctrl.sv
// rtl/systolic_seq_ctrl.sv - job sequencer for an N x N weight-stationary systolic array
module systolic_seq_ctrl #(
  parameter int N        = 3,
  parameter int ROW_W    = 8,
  parameter int TILE_W   = 4,
  parameter int ADDR_W   = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ROW_W-1:0]  cfg_rows,
  input  logic [TILE_W-1:0] cfg_tiles,
  input  logic [ADDR_W-1:0] cfg_acc_base,
  input  logic              cfg_clear,
  input  logic              cfg_accum,
  input  logic              cfg_reload,
  input  logic              acc_clear_complete,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              en_weight_pass,
  output logic [N*N-1:0]    en_capture,
  output logic              systolic_active,
  output logic [7:0]        weight_load_cnt,
  output logic              acc_clear,
  output logic              acc_wr_en,
  output logic [ADDR_W-1:0] acc_wr_addr,
  output logic              acc_wr_accum,
  output logic [TILE_W-1:0] tile_idx
);

  localparam int LOAD_LAST = 3 * N - 2;
  localparam int CNT_W     = $clog2(PIPE_LAT + N + (1 << ROW_W) + 1);
  localparam logic [CNT_W-1:0] WR_FIRST = CNT_W'(PIPE_LAT + N - 1);
  localparam logic [CNT_W-1:0] WR_BIAS  = CNT_W'(PIPE_LAT + N - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_COMPUTE, S_WAIT, S_DONE
  } state_t;

  state_t            state, state_next;
  logic [ROW_W-1:0]  rows_q;
  logic [TILE_W-1:0] tiles_q;
  logic [TILE_W-1:0] tile_q;
  logic              accum_q;
  logic              reload_q;
  logic              aborted_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        load_cnt_q;
  logic [CNT_W-1:0]  cmp_cnt_q;
  logic [CNT_W-1:0]  wr_last;
  logic              wr_window;
  logic              accept;
  logic              load_enter;
  logic              cmp_enter;
  logic              tile_inc;

  // Row r's result leaves column 0 at cmp_cnt PIPE_LAT+N-1+r.
  assign wr_last   = WR_BIAS + CNT_W'(rows_q);
  assign wr_window = (cmp_cnt_q >= WR_FIRST) && (cmp_cnt_q <= wr_last);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next      = state;
    accept          = 1'b0;
    load_enter      = 1'b0;
    cmp_enter       = 1'b0;
    tile_inc        = 1'b0;
    busy            = (state != S_IDLE);
    done            = (state == S_DONE);
    en_weight_pass  = (state == S_LOAD);
    systolic_active = (state == S_COMPUTE);
    acc_clear       = (state == S_CLEAR);
    acc_wr_en       = (state == S_COMPUTE) && wr_window;
    en_capture      = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        en_capture[r*N+c] = (state == S_LOAD) && (load_cnt_q == 8'(2*r + c + 1));
      end
    end

    if (state != S_IDLE && abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          accept = 1'b1;
          if (cfg_rows == '0 || cfg_tiles == '0) begin
            state_next = S_DONE;
          end else if (cfg_clear) begin
            state_next = S_CLEAR;
          end else begin
            state_next = S_LOAD;
            load_enter = 1'b1;
          end
        end
        S_CLEAR: if (acc_clear_complete) begin
          state_next = S_LOAD;
          load_enter = 1'b1;
        end
        S_LOAD: if (load_cnt_q == 8'(LOAD_LAST)) begin
          state_next = S_COMPUTE;
          cmp_enter  = 1'b1;
        end
        S_COMPUTE: if (cmp_cnt_q == wr_last) state_next = S_WAIT;
        S_WAIT: begin
          if (tile_q == tiles_q - TILE_W'(1)) begin
            state_next = S_DONE;
          end else begin
            tile_inc = 1'b1;
            if (reload_q) begin
              state_next = S_LOAD;
              load_enter = 1'b1;
            end else begin
              state_next = S_COMPUTE;
              cmp_enter  = 1'b1;
            end
          end
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q     <= '0;
      tiles_q    <= '0;
      tile_q     <= '0;
      accum_q    <= 1'b0;
      reload_q   <= 1'b0;
      aborted_q  <= 1'b0;
      addr_q     <= '0;
      load_cnt_q <= '0;
      cmp_cnt_q  <= '0;
    end else begin
      aborted_q <= abort && (state != S_IDLE);
      if (accept) begin
        rows_q   <= cfg_rows;
        tiles_q  <= cfg_tiles;
        accum_q  <= cfg_accum;
        reload_q <= cfg_reload;
        addr_q   <= cfg_acc_base;
        tile_q   <= '0;
      end
      if (load_enter)
        load_cnt_q <= 8'd1;
      else if (state == S_LOAD && state_next == S_LOAD)
        load_cnt_q <= load_cnt_q + 8'd1;
      else
        load_cnt_q <= '0;
      if (cmp_enter)
        cmp_cnt_q <= '0;
      else if (state == S_COMPUTE)
        cmp_cnt_q <= cmp_cnt_q + CNT_W'(1);
      // Write address keeps running across tiles and wraps naturally.
      if (acc_wr_en) addr_q <= addr_q + ADDR_W'(1);
      if (tile_inc)  tile_q <= tile_q + TILE_W'(1);
    end
  end

  assign aborted         = aborted_q;
  assign weight_load_cnt = load_cnt_q;
  assign acc_wr_addr     = addr_q;
  assign acc_wr_accum    = accum_q;
  assign tile_idx        = tile_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb/tb_systolic_seq_ctrl.sv - randomized bench for systolic_seq_ctrl against a phase-level job model
module tb_systolic_seq_ctrl;

  localparam int N        = 3;
  localparam int PIPE_LAT = 4;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] cfg_rows;
  logic [3:0] cfg_tiles;
  logic [7:0] cfg_acc_base;
  logic       cfg_clear, cfg_accum, cfg_reload, acc_clear_complete;
  logic       busy, done, aborted, en_weight_pass, systolic_active;
  logic [8:0] en_capture;
  logic [7:0] weight_load_cnt;
  logic       acc_clear, acc_wr_en, acc_wr_accum;
  logic [7:0] acc_wr_addr;
  logic [3:0] tile_idx;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic busy, done, aborted, ewp, sact, aclr, wr_en, wr_acc;
    logic [7:0] lcnt;
    logic [8:0] cap;
    logic [7:0] addr;
    logic [3:0] tile;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];

  systolic_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_rows(cfg_rows), .cfg_tiles(cfg_tiles), .cfg_acc_base(cfg_acc_base),
    .cfg_clear(cfg_clear), .cfg_accum(cfg_accum), .cfg_reload(cfg_reload),
    .acc_clear_complete(acc_clear_complete), .busy(busy), .done(done), .aborted(aborted),
    .en_weight_pass(en_weight_pass), .en_capture(en_capture), .systolic_active(systolic_active),
    .weight_load_cnt(weight_load_cnt), .acc_clear(acc_clear), .acc_wr_en(acc_wr_en),
    .acc_wr_addr(acc_wr_addr), .acc_wr_accum(acc_wr_accum), .tile_idx(tile_idx)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o = '{busy, done, aborted, en_weight_pass, systolic_active, acc_clear, acc_wr_en,
          acc_wr_accum, weight_load_cnt, en_capture, acc_wr_addr, tile_idx};
    if (!o.wr_en) begin
      o.addr = '0; o.tile = '0; o.wr_acc = 1'b0;
    end
    return o;
  endfunction

  // Expected per-cycle outputs for t = 1.. after the start edge, built phase by phase.
  task automatic build_exp(input int rows, tiles, base, clr, acc, rel, dly, abort_at, tail);
    obs_t e;
    int   addr, c_len;
    exp_q.delete();
    if (rows == 0 || tiles == 0) begin
      e = '0; e.busy = 1; e.done = 1; exp_q.push_back(e);
    end else begin
      if (clr != 0) repeat (dly) begin
        e = '0; e.busy = 1; e.aclr = 1; exp_q.push_back(e);
      end
      addr  = base;
      c_len = PIPE_LAT + N - 1 + rows;
      for (int t = 0; t < tiles; t++) begin
        if (t == 0 || rel != 0) begin
          for (int k = 1; k <= 3*N-2; k++) begin
            e = '0; e.busy = 1; e.ewp = 1; e.lcnt = 8'(k);
            for (int r = 0; r < N; r++)
              for (int c = 0; c < N; c++)
                if (2*r + c + 1 == k) e.cap[r*N+c] = 1'b1;
            exp_q.push_back(e);
          end
        end
        for (int m = 0; m < c_len; m++) begin
          e = '0; e.busy = 1; e.sact = 1;
          if (m >= c_len - rows) begin
            e.wr_en = 1; e.wr_acc = acc[0]; e.addr = 8'(addr); e.tile = 4'(t);
            addr++;
          end
          exp_q.push_back(e);
        end
        e = '0; e.busy = 1; exp_q.push_back(e);
      end
      e = '0; e.busy = 1; e.done = 1; exp_q.push_back(e);
    end
    if (abort_at >= 1 && abort_at <= exp_q.size() && exp_q[abort_at-1].busy) begin
      while (exp_q.size() > abort_at) void'(exp_q.pop_back());
      e = '0; e.aborted = 1; exp_q.push_back(e);
    end
    repeat (tail) exp_q.push_back('0);
  endtask

  task automatic run_job(input int rows, tiles, base, clr, acc, rel, dly, abort_at, tail);
    build_exp(rows, tiles, base, clr, acc, rel, dly, abort_at, tail);
    obs_q.delete();
    @(negedge clk);
    start = 1; cfg_rows = 8'(rows); cfg_tiles = 4'(tiles); cfg_acc_base = 8'(base);
    cfg_clear = clr[0]; cfg_accum = acc[0]; cfg_reload = rel[0];
    abort = 0; acc_clear_complete = 0;
    for (int j = 1; j <= exp_q.size(); j++) begin
      @(negedge clk);
      obs_q.push_back(sample());
      // Junk start/cfg while busy must be ignored.
      start = exp_q[j-1].busy ? 1'($urandom) : 1'b0;
      cfg_rows = 8'($urandom); cfg_tiles = 4'($urandom); cfg_acc_base = 8'($urandom);
      cfg_clear = 1'($urandom); cfg_accum = 1'($urandom); cfg_reload = 1'($urandom);
      abort = (j == abort_at);
      if (clr != 0 && rows != 0 && tiles != 0 && j <= dly) acc_clear_complete = (j == dly);
      else acc_clear_complete = 1'($urandom);
    end
    start = 0; abort = 0; acc_clear_complete = 0;
  endtask

  task automatic test_reset();
    logic [36:0] all_o;
    rst = 1; start = 0; abort = 0; acc_clear_complete = 0;
    cfg_rows = 0; cfg_tiles = 0; cfg_acc_base = 0; cfg_clear = 0; cfg_accum = 0; cfg_reload = 0;
    repeat (3) @(negedge clk);
    all_o = {busy, done, aborted, en_weight_pass, en_capture, systolic_active, weight_load_cnt,
             acc_clear, acc_wr_en, acc_wr_addr, acc_wr_accum, tile_idx};
    tests++;
    if (all_o !== '0) begin fails++; $display("FAIL reset_state: got %h want 0", all_o); end
    rst = 0;
    start = 1; cfg_rows = 3; cfg_tiles = 2; cfg_clear = 1; cfg_accum = 1; cfg_acc_base = 8'h77;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, acc_clear} !== 2'b11) begin
      fails++; $display("FAIL reset_prejob_clear: got %b want 11", {busy, acc_clear});
    end
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 0;
      all_o = {busy, done, aborted, en_weight_pass, en_capture, systolic_active, weight_load_cnt,
               acc_clear, acc_wr_en, acc_wr_addr, acc_wr_accum, tile_idx};
      tests++;
      if (all_o !== '0) begin fails++; $display("FAIL reset_midjob[%0d]: got %h want 0", i, all_o); end
    end
  endtask

  task automatic test_basic();
    int exp_cap[9] = '{1, 2, 3, 3, 4, 5, 5, 6, 7};
    int n_cap, first, n_wr, n_done;
    run_job(3, 1, 'h10, 0, 1, 0, 0, 0, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL basic_trace t=%0d: got %h want %h", i+1, obs_q[i], exp_q[i]);
      end
    end
    for (int pe = 0; pe < 9; pe++) begin
      n_cap = 0; first = -1;
      foreach (obs_q[i]) if (obs_q[i].cap[pe]) begin n_cap++; first = obs_q[i].lcnt; end
      tests++;
      if (n_cap != 1 || first != exp_cap[pe]) begin
        fails++; $display("FAIL basic_capture pe%0d: got %0d pulses at cnt %0d want 1 at %0d",
                          pe, n_cap, first, exp_cap[pe]);
      end
    end
    n_wr = 0; n_done = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i].done) n_done++;
      if (obs_q[i].wr_en) begin
        tests++;
        // COMPUTE begins at t=8 (index 7), so cmp_cnt = index - 7.
        if (obs_q[i].addr !== 8'(8'h10 + n_wr) || (i - 7) != 6 + n_wr) begin
          fails++; $display("FAIL basic_write%0d: got addr %h cmp %0d want %h cmp %0d",
                            n_wr, obs_q[i].addr, i - 7, 8'h10 + n_wr, 6 + n_wr);
        end
        n_wr++;
      end
    end
    tests++;
    if (n_wr != 3 || n_done != 1) begin
      fails++; $display("FAIL basic_counts: got %0d writes %0d done want 3 1", n_wr, n_done);
    end
  endtask

  task automatic test_clear();
    int n_clr;
    run_job(3, 1, 'h40, 1, 0, 0, 256, 0, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL clear_trace t=%0d: got %h want %h", i+1, obs_q[i], exp_q[i]);
      end
    end
    n_clr = 0;
    foreach (obs_q[i]) if (obs_q[i].aclr) n_clr++;
    tests++;
    if (n_clr != 256 || obs_q[256].ewp !== 1'b1 || obs_q[256].lcnt !== 8'd1) begin
      fails++; $display("FAIL clear_hold: got %0d clear cycles ewp %b cnt %0d want 256 1 1",
                        n_clr, obs_q[256].ewp, obs_q[256].lcnt);
    end
  endtask

  task automatic test_multitile_noreload();
    logic [7:0] exp_addr[6] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
    int n_load, n_wr;
    run_job(2, 3, 'hFE, 0, 1, 0, 0, 0, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL multitile_trace t=%0d: got %h want %h", i+1, obs_q[i], exp_q[i]);
      end
    end
    n_load = 0; n_wr = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i].ewp) n_load++;
      if (obs_q[i].wr_en) begin
        tests++;
        if (n_wr > 5 || obs_q[i].addr !== exp_addr[n_wr % 6] || obs_q[i].tile !== 4'(n_wr / 2)) begin
          fails++; $display("FAIL multitile_write%0d: got addr %h tile %0d want %h %0d",
                            n_wr, obs_q[i].addr, obs_q[i].tile, exp_addr[n_wr % 6], n_wr / 2);
        end
        n_wr++;
      end
    end
    tests++;
    if (n_load != 7 || n_wr != 6) begin
      fails++; $display("FAIL multitile_counts: got %0d load %0d writes want 7 6", n_load, n_wr);
    end
  endtask

  task automatic test_reload();
    int n_load, n_bad;
    for (int acc = 0; acc < 2; acc++) begin
      run_job(2, 2, 'h20, 0, acc, 1, 0, 0, 2);
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL reload_trace acc=%0d t=%0d: got %h want %h", acc, i+1, obs_q[i], exp_q[i]);
        end
      end
      n_load = 0; n_bad = 0;
      foreach (obs_q[i]) begin
        if (obs_q[i].ewp) n_load++;
        if (obs_q[i].wr_en && obs_q[i].wr_acc !== acc[0]) n_bad++;
      end
      tests++;
      if (n_load != 14 || n_bad != 0) begin
        fails++; $display("FAIL reload_counts acc=%0d: got %0d load %0d bad accum want 14 0", acc, n_load, n_bad);
      end
    end
  endtask

  task automatic test_abort();
    int ab, n_late_wr, n_done, n_ab;
    ab = (3*N - 2) + (PIPE_LAT + N - 1) + 2;
    run_job(3, 1, 'h10, 0, 0, 0, 0, ab, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL abort_trace t=%0d: got %h want %h", i+1, obs_q[i], exp_q[i]);
      end
    end
    n_late_wr = 0; n_done = 0; n_ab = 0;
    foreach (obs_q[i]) begin
      if (i >= ab && obs_q[i].wr_en) n_late_wr++;
      if (obs_q[i].done) n_done++;
      if (obs_q[i].aborted) n_ab++;
    end
    tests++;
    if (n_late_wr != 0 || n_done != 0 || n_ab != 1 || obs_q[ab].busy !== 1'b0) begin
      fails++; $display("FAIL abort_effect: got late_wr %0d done %0d aborted %0d busy %b want 0 0 1 0",
                        n_late_wr, n_done, n_ab, obs_q[ab].busy);
    end
  endtask

  task automatic test_zero_rows();
    int n_wr, n_cap;
    for (int v = 0; v < 2; v++) begin
      run_job(v == 0 ? 0 : 4, v == 0 ? 2 : 0, 'h33, 1, 0, 0, 3, 0, 2);
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL zero_trace v=%0d t=%0d: got %h want %h", v, i+1, obs_q[i], exp_q[i]);
        end
      end
      n_wr = 0; n_cap = 0;
      foreach (obs_q[i]) begin
        if (obs_q[i].wr_en) n_wr++;
        if (obs_q[i].cap != 0) n_cap++;
      end
      tests++;
      if (obs_q[0].done !== 1'b1 || n_wr != 0 || n_cap != 0) begin
        fails++; $display("FAIL zero_job v=%0d: got done %b writes %0d caps %0d want 1 0 0",
                          v, obs_q[0].done, n_wr, n_cap);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_job(1, 1, 'h50, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL b2b_first t=%0d: got %h want %h", i+1, obs_q[i], exp_q[i]);
      end
    end
    run_job(2, 1, 'h60, 0, 1, 0, 0, 0, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL b2b_second t=%0d: got %h want %h", i+1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int rows, tiles, base, clr, acc, rel, dly, ab;
    for (int it = 0; it < 10; it++) begin
      rows  = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 5);
      tiles = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 3);
      base  = $urandom % 256;
      clr   = $urandom % 2;  acc = $urandom % 2;  rel = $urandom % 2;
      dly   = $urandom_range(1, 5);
      build_exp(rows, tiles, base, clr, acc, rel, dly, 0, 2);
      ab = ($urandom % 3 == 0) ? $urandom_range(1, exp_q.size() - 2) : 0;
      run_job(rows, tiles, base, clr, acc, rel, dly, ab, 2);
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL random%0d t=%0d (r%0d t%0d c%0d rl%0d ab%0d): got %h want %h",
                            it, i+1, rows, tiles, clr, rel, ab, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clear();
    test_multitile_noreload();
    test_reload();
    test_abort();
    test_zero_rows();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
